decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode stage.
- Classifies the opcode into an instruction format, derives the register-write enable, extracts register indices and builds the sign-extended immediate.
- Flags illegal encodings and counts them in a saturating counter.
- Sits between fetch and the register-file/execute stage with a valid/ready handshake on both sides, plus a flush input for branch redirects.

Parameters:
- XLEN, 32, datapath width for pc and immediate (32 or 64).
- ENABLE_M, 0, 1 = R-type with funct7=7'b0000001 is legal (M extension).
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  discard the held output and block capture this cycle.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  XLEN  pc of instruction.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_pc  output  XLEN  registered pc.
- out_fmt  output  4  format code.
- out_writereg  output  1  equals out_fmt[3].
- out_rd / out_rs1 / out_rs2  output  5 each  instr[11:7] / [19:15] / [24:20].
- out_funct3  output  3  instr[14:12].
- out_funct7  output  7  instr[31:25].
- out_imm  output  XLEN  sign-extended immediate.
- out_illegal  output  1  instruction illegal.
- illegal_count  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Format codes:
  - R = 4'b1000, I = 4'b1001, U = 4'b1010, J = 4'b1011, S = 4'b0100, B = 4'b0101, ILLEGAL = 4'b0000.
  - Bit 3 is the register-write enable.
- Opcode map:
  - 0110111 and 0010111 -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0010011 -> I.
  - 1100011 -> B.
  - 0100011 -> S.
  - 0110011 -> R.
  - Any other opcode -> ILLEGAL, out_illegal = 1.
- R-type legality:
  - R-type with funct7 not in {0000000, 0100000}, and not 0000001 when ENABLE_M = 1, is illegal.
  - An illegal instruction always gets fmt = ILLEGAL, which forces writereg = 0.
  - Field outputs still carry the raw bits.
- Immediates (all sign-extended from instr[31] to XLEN):
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R and ILLEGAL: imm = 0.
- Handshake (single pipeline register, latency 1 cycle):
  - in_ready = !out_valid || out_ready (combinational).
  - Capture when in_valid && in_ready && !flush: all out_* load from the decode of in_instr; out_valid <= 1.
  - Else, when out_ready && out_valid, or when flush: out_valid <= 0.
  - Simultaneous drain and capture loads the new bundle with no bubble.
  - When out_valid = 1 and out_ready = 0, all out_* hold stable.
- Flush:
  - flush has priority over capture and over reset-free holding.
  - flush = 1 -> out_valid = 0 on the next edge, and no capture that cycle, even if in_valid.
  - in_ready is still computed as above; fetch sees its instruction consumed, which is the intended discard.
- illegal_count:
  - Increments by 1 on each capture whose decode is illegal.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush.
- Reset (rst_n = 0 at a rising edge) forces, regardless of other inputs including mid-handshake:
  - out_valid = 0, out_pc = 0, out_fmt = 0, out_writereg = 0, out_illegal = 0.
  - out_rd = out_rs1 = out_rs2 = 0, out_funct3 = 0, out_funct7 = 0, out_imm = 0, illegal_count = 0.
- No X values on any output in any state.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), pc 0x100, out_ready = 1 -> next cycle:
  - out_valid = 1, fmt = 1001, writereg = 1, rd = 1.
  - imm = 0xFFFFFFFF, pc = 0x100, illegal = 0.
- lui x5,0x12345 (0x123452B7) -> fmt = 1010, rd = 5, imm = 0x12345000. beq x0,x0,-4 (0xFE000EE3) -> fmt = 0101, writereg = 0, imm = 0xFFFFFFFC.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles with in_valid = 1 and a second word queued.
  - Required: in_ready = 0, outputs hold the first bundle.
  - Release: first bundle accepted, second loaded the same edge, with no bubble or duplicate.
- Illegal words:
  - 0x00000000 -> fmt = 0000, illegal = 1, writereg = 0, illegal_count = 1.
  - 0x02000033 with ENABLE_M = 0 -> illegal, count = 2.
  - With ENABLE_M = 1 -> fmt = 1000, count unchanged.
- Flush while out_valid = 1, out_ready = 0, in_valid = 1 -> next cycle out_valid = 0 and nothing captured. Counter saturation with CNT_W = 2: 5 illegal captures -> count = 3.
- Assert rst_n = 0 mid-stall with out_valid = 1 and count = 2 -> next edge: all outputs 0. After release, capture resumes normally.

Source files
------------

// File: rtl/decode_stage.sv
// Purpose : registered RV32I/RV64I decode: format class, write enable, register fields, sign-extended immediate, illegal flag and count.
// Latency : 1 cycle from an accepted in_valid/in_ready beat to out_valid.
// Backpres: in_ready = !out_valid || out_ready; a stalled bundle holds stable, and flush drops it and blocks capture that cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   flush                 drop the held bundle; no capture this cycle
//   in_valid/in_ready     fetch-side handshake; in_instr (32b), in_pc (XLEN)
//   out_valid/out_ready   execute-side handshake
//   out_pc, out_fmt, out_writereg, out_rd, out_rs1, out_rs2,
//   out_funct3, out_funct7, out_imm, out_illegal   registered decode bundle
//   illegal_count         saturating count of captured illegal instructions
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_fmt,
  output logic             out_writereg,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  // Bit 3 of the format code doubles as the register-write enable.
  localparam logic [3:0] FMT_R   = 4'b1000;
  localparam logic [3:0] FMT_I   = 4'b1001;
  localparam logic [3:0] FMT_U   = 4'b1010;
  localparam logic [3:0] FMT_J   = 4'b1011;
  localparam logic [3:0] FMT_S   = 4'b0100;
  localparam logic [3:0] FMT_B   = 4'b0101;
  localparam logic [3:0] FMT_ILL = 4'b0000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic            r_legal;
  logic [3:0]      fmt_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d;
  logic            illegal_d;
  logic            capture;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];

  // Base ALU ops use funct7 0000000 / 0100000; 0000001 is the M-extension group.
  assign r_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) ||
                   (ENABLE_M && (funct7 == 7'b0000001));

  // Immediates are built at 32 bits and sign-extended to XLEN afterwards,
  // so one set of concatenations serves both RV32 and RV64.
  always_comb begin
    fmt_d = FMT_ILL;
    imm32 = '0;
    case (opcode)
      7'b0110111, 7'b0010111: begin
        fmt_d = FMT_U;
        imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt_d = FMT_J;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        fmt_d = FMT_I;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1100011: begin
        fmt_d = FMT_B;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0100011: begin
        fmt_d = FMT_S;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b0110011: begin
        fmt_d = r_legal ? FMT_R : FMT_ILL;
      end
      default: begin
        fmt_d = FMT_ILL;
      end
    endcase
  end

  assign imm_d     = XLEN'($signed(imm32));
  assign illegal_d = (fmt_d == FMT_ILL);

  assign in_ready     = !out_valid || out_ready;
  assign capture      = in_valid && in_ready && !flush;
  assign out_writereg = out_fmt[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_fmt       <= FMT_ILL;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_imm       <= '0;
      out_illegal   <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (capture) begin
        // A drain and a capture on the same edge simply overwrite: no bubble.
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_fmt     <= fmt_d;
        out_rd      <= in_instr[11:7];
        out_rs1     <= in_instr[19:15];
        out_rs2     <= in_instr[24:20];
        out_funct3  <= in_instr[14:12];
        out_funct7  <= in_instr[31:25];
        out_imm     <= imm_d;
        out_illegal <= illegal_d;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end

      if (capture && illegal_d && (illegal_count != CNT_MAX)) begin
        illegal_count <= illegal_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Purpose : scoreboard bench for decode_stage, three parameterisations driven in lockstep.
// Latency : expectations are queued at the capture edge, compared at each output handshake.
// Backpres: stimulus drives stalls, flush and reset mid-stall; the monitor only pops on out_valid && out_ready.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  // Main instance: ENABLE_M = 0, CNT_W = 16
  logic        in_ready, out_valid, out_writereg, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [3:0]  out_fmt;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [15:0] illegal_count;

  // M instance: ENABLE_M = 1, CNT_W = 16
  logic        m_in_ready, m_out_valid, m_out_writereg, m_out_illegal;
  logic [31:0] m_out_pc, m_out_imm;
  logic [3:0]  m_out_fmt;
  logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
  logic [2:0]  m_out_funct3;
  logic [6:0]  m_out_funct7;
  logic [15:0] m_illegal_count;

  // Saturation instance: ENABLE_M = 0, CNT_W = 2
  logic        c_in_ready, c_out_valid, c_out_writereg, c_out_illegal;
  logic [31:0] c_out_pc, c_out_imm;
  logic [3:0]  c_out_fmt;
  logic [4:0]  c_out_rd, c_out_rs1, c_out_rs2;
  logic [2:0]  c_out_funct3;
  logic [6:0]  c_out_funct7;
  logic [1:0]  c_illegal_count;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_fmt(out_fmt), .out_writereg(out_writereg), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_fmt(m_out_fmt), .out_writereg(m_out_writereg), .out_rd(m_out_rd),
    .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_funct3(m_out_funct3), .out_funct7(m_out_funct7),
    .out_imm(m_out_imm), .out_illegal(m_out_illegal), .illegal_count(m_illegal_count)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_pc(c_out_pc), .out_fmt(c_out_fmt), .out_writereg(c_out_writereg), .out_rd(c_out_rd),
    .out_rs1(c_out_rs1), .out_rs2(c_out_rs2), .out_funct3(c_out_funct3), .out_funct7(c_out_funct7),
    .out_imm(c_out_imm), .out_illegal(c_out_illegal), .illegal_count(c_illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
    logic [15:0] cnt;
    logic [3:0]  fmt_m;
    logic [15:0] cnt_m;
    logic [1:0]  cnt_c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] fmt,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                              input logic ill, input logic [15:0] cnt, input logic [3:0] fmt_m,
                              input logic [15:0] cnt_m, input logic [1:0] cnt_c);
    exp_t e;
    e.pc = pc; e.fmt = fmt; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7;
    e.imm = imm; e.ill = ill; e.cnt = cnt; e.fmt_m = fmt_m; e.cnt_m = cnt_m; e.cnt_c = cnt_c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_bundle: got pc 0x%0h expected no bundle", out_pc);
      end else begin
        mon_e = q.pop_front();
        chk("pc",        out_pc,          mon_e.pc);
        chk("fmt",       out_fmt,         mon_e.fmt);
        chk("writereg",  out_writereg,    mon_e.fmt[3]);
        chk("rd",        out_rd,          mon_e.rd);
        chk("rs1",       out_rs1,         mon_e.rs1);
        chk("rs2",       out_rs2,         mon_e.rs2);
        chk("funct3",    out_funct3,      mon_e.f3);
        chk("funct7",    out_funct7,      mon_e.f7);
        chk("imm",       out_imm,         mon_e.imm);
        chk("illegal",   out_illegal,     mon_e.ill);
        chk("count",     illegal_count,   mon_e.cnt);
        chk("m_fmt",     m_out_fmt,       mon_e.fmt_m);
        chk("m_count",   m_illegal_count, mon_e.cnt_m);
        chk("sat_count", c_illegal_count, mon_e.cnt_c);
      end
    end
  end

  // Called at posedge+1; presents one word and queues its expectation at the capture edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    int n;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for pc 0x%0h, required 1", pc);
    end else begin
      @(posedge clk);
      q.push_back(e);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;

    chk("rst_out_valid", out_valid,     0);
    chk("rst_in_ready",  in_ready,      1);
    chk("rst_fmt",       out_fmt,       0);
    chk("rst_imm",       out_imm,       0);
    chk("rst_count",     illegal_count, 0);

    // Legal formats, streamed back to back.
    send(32'hFFF00093, 32'h100, mk(32'h100, 4'h9, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0, 16'd0, 4'h9, 16'd0, 2'd0));
    send(32'h123452B7, 32'h104, mk(32'h104, 4'hA, 5'd5,  5'd8, 5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0, 16'd0, 4'hA, 16'd0, 2'd0));
    send(32'hFE000EE3, 32'h108, mk(32'h108, 4'h5, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0, 16'd0, 4'h5, 16'd0, 2'd0));
    send(32'h002081B3, 32'h10C, mk(32'h10C, 4'h8, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'h00000000, 1'b0, 16'd0, 4'h8, 16'd0, 2'd0));
    idle(2);

    // Backpressure: hold a store while a jal waits, then release.
    out_ready = 1'b0;
    send(32'h0020A423, 32'h110, mk(32'h110, 4'h4, 5'd8, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8, 1'b0, 16'd0, 4'h4, 16'd0, 2'd0));
    in_valid = 1'b1;
    in_instr = 32'h008000EF;
    in_pc    = 32'h114;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_pc",       out_pc,   32'h110);
      chk("stall_fmt",      out_fmt,  4'h4);
      chk("stall_imm",      out_imm,  32'h8);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    q.push_back(mk(32'h114, 4'hB, 5'd1, 5'd0, 5'd8, 3'd0, 7'h00, 32'h8, 1'b0, 16'd0, 4'hB, 16'd0, 2'd0));
    #1;
    in_valid = 1'b0;
    chk("nobubble_valid", out_valid, 1);
    chk("nobubble_pc",    out_pc,    32'h114);
    idle(2);

    // Illegal words and counter saturation (the 2-bit counter stops at 3).
    send(32'h00000000, 32'h118, mk(32'h118, 4'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1, 16'd1, 4'h0, 16'd1, 2'd1));
    send(32'h02000033, 32'h11C, mk(32'h11C, 4'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h01, 32'h0, 1'b1, 16'd2, 4'h8, 16'd1, 2'd2));
    send(32'h00000000, 32'h120, mk(32'h120, 4'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1, 16'd3, 4'h0, 16'd2, 2'd3));
    send(32'h00000000, 32'h124, mk(32'h124, 4'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1, 16'd4, 4'h0, 16'd3, 2'd3));
    send(32'h00000000, 32'h128, mk(32'h128, 4'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1, 16'd5, 4'h0, 16'd4, 2'd3));
    idle(2);

    // Flush a stalled bundle, then flush with in_ready high: nothing is captured.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00000093;
    in_pc     = 32'h200;
    @(posedge clk); #1;
    chk("preflush_valid", out_valid, 1);
    chk("preflush_pc",    out_pc,    32'h200);
    flush    = 1'b1;
    in_instr = 32'h00000000;
    in_pc    = 32'h204;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("flush_valid",  out_valid,     0);
    chk("flush_count",  illegal_count, 16'd5);
    chk("flush_ready2", in_ready,      1);
    @(posedge clk); #1;
    chk("flush2_valid", out_valid,     0);
    chk("flush2_count", illegal_count, 16'd5);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Reset in the middle of a stall with a nonzero count.
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    in_pc    = 32'h300;
    @(posedge clk); #1;
    chk("prerst_valid", out_valid,     1);
    chk("prerst_count", illegal_count, 16'd6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst2_valid",    out_valid,       0);
    chk("rst2_pc",       out_pc,          0);
    chk("rst2_fmt",      out_fmt,         0);
    chk("rst2_writereg", out_writereg,    0);
    chk("rst2_fields",   {out_rd, out_rs1, out_rs2, out_funct3, out_funct7}, 0);
    chk("rst2_imm",      out_imm,         0);
    chk("rst2_illegal",  out_illegal,     0);
    chk("rst2_count",    illegal_count,   0);
    chk("rst2_m_count",  m_illegal_count, 0);
    chk("rst2_c_count",  c_illegal_count, 0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    send(32'hFFF00093, 32'h400, mk(32'h400, 4'h9, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0, 16'd0, 4'h9, 16'd0, 2'd0));
    send(32'h00000000, 32'h404, mk(32'h404, 4'h0, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        1'b1, 16'd1, 4'h0, 16'd1, 2'd1));
    idle(4);

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
